// File: rtl/axi_lite_sram_slv.sv
`default_nettype none
// ============================================================================
// axi_lite_sram_slv : AXI4-Lite responder in front of a word-wide SRAM array,
//                     with independent read/write FSMs and programmable latency.
// Revision 1.0
// ============================================================================
module axi_lite_sram_slv #(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       DEPTH     = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
   parameter int unsigned       RD_LAT    = 2,
   parameter int unsigned       WR_LAT    = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                slv_ar_valid_i,
   input  logic [ADDR_W-1:0]   slv_ar_addr_i,
   output logic                slv_ar_ready_o,
   output logic                slv_r_valid_o,
   output logic [DATA_W-1:0]   slv_r_data_o,
   output logic [1:0]          slv_r_resp_o,
   input  logic                slv_r_ready_i,
   input  logic                slv_aw_valid_i,
   input  logic [ADDR_W-1:0]   slv_aw_addr_i,
   output logic                slv_aw_ready_o,
   input  logic                slv_w_valid_i,
   input  logic [DATA_W-1:0]   slv_w_data_i,
   input  logic [DATA_W/8-1:0] slv_w_strb_i,
   output logic                slv_w_ready_o,
   output logic                slv_b_valid_o,
   output logic [1:0]          slv_b_resp_o,
   input  logic                slv_b_ready_i
);

   localparam int unsigned       STRB_W = DATA_W / 8;
   localparam int unsigned       OFS_W  = $clog2(STRB_W);
   localparam int unsigned       IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned       AW1    = ADDR_W + 1;
   localparam logic [ADDR_W:0]   SPAN   = AW1'(DEPTH * STRB_W);
   localparam logic [3:0]        RD_CNT = 4'(RD_LAT);
   localparam logic [3:0]        WR_CNT = 4'(WR_LAT);
   localparam logic [1:0]        OKAY   = 2'b00;
   localparam logic [1:0]        DECERR = 2'b11;

   typedef enum logic [1:0] {R_IDLE, R_DLY, R_RSP} r_state_e;
   typedef enum logic [1:0] {W_IDLE, W_DLY, W_RSP} w_state_e;

   logic [DATA_W-1:0] mem_q [DEPTH];

   // ---------------- read path ----------------
   r_state_e          r_state_q, r_state_d;
   logic [3:0]        r_cnt_q, r_cnt_d;
   logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
   logic [DATA_W-1:0] r_data_q, r_data_d;
   logic [1:0]        r_resp_q, r_resp_d;
   logic              r_valid_q, r_valid_d;
   logic              ar_ready_q, ar_ready_d;

   // The one-bit extension makes addresses below BASE_ADDR wrap to a huge
   // offset, so the single compare against SPAN rejects both ends.
   logic [ADDR_W:0]   w_rd_ofs;
   logic              w_rd_hit;
   logic [IDX_W-1:0]  w_rd_idx;

   assign w_rd_ofs = {1'b0, ar_addr_q} - {1'b0, BASE_ADDR};
   assign w_rd_hit = (ar_addr_q >= BASE_ADDR) && (w_rd_ofs < SPAN);
   assign w_rd_idx = w_rd_ofs[IDX_W+OFS_W-1 -: IDX_W];

   always_comb begin
      r_state_d = r_state_q;
      r_cnt_d   = r_cnt_q;
      ar_addr_d = ar_addr_q;
      r_data_d  = r_data_q;
      r_resp_d  = r_resp_q;
      r_valid_d = r_valid_q;
      case (r_state_q)
         R_IDLE: begin
            if (slv_ar_valid_i && ar_ready_q) begin
               ar_addr_d = slv_ar_addr_i;
               r_cnt_d   = '0;
               r_state_d = R_DLY;
            end
         end
         R_DLY: begin
            if (r_cnt_q == RD_CNT) begin
               r_state_d = R_RSP;
               r_valid_d = 1'b1;
               r_data_d  = w_rd_hit ? mem_q[w_rd_idx] : '0;
               r_resp_d  = w_rd_hit ? OKAY : DECERR;
            end else begin
               r_cnt_d = r_cnt_q + 4'd1;
            end
         end
         R_RSP: begin
            if (slv_r_ready_i) begin
               r_valid_d = 1'b0;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      ar_ready_d = (r_state_d == R_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state_q  <= R_IDLE;
         r_cnt_q    <= '0;
         ar_addr_q  <= '0;
         r_data_q   <= '0;
         r_resp_q   <= OKAY;
         r_valid_q  <= 1'b0;
         ar_ready_q <= 1'b0;
      end else begin
         r_state_q  <= r_state_d;
         r_cnt_q    <= r_cnt_d;
         ar_addr_q  <= ar_addr_d;
         r_data_q   <= r_data_d;
         r_resp_q   <= r_resp_d;
         r_valid_q  <= r_valid_d;
         ar_ready_q <= ar_ready_d;
      end
   end

   // ---------------- write path ----------------
   w_state_e          w_state_q, w_state_d;
   logic [3:0]        w_cnt_q, w_cnt_d;
   logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
   logic [DATA_W-1:0] w_data_q, w_data_d;
   logic [STRB_W-1:0] w_strb_q, w_strb_d;
   logic              aw_got_q, aw_got_d;
   logic              w_got_q, w_got_d;
   logic [1:0]        b_resp_q, b_resp_d;
   logic              b_valid_q, b_valid_d;
   logic              aw_ready_q, aw_ready_d;
   logic              w_ready_q, w_ready_d;

   logic [ADDR_W:0]   w_wr_ofs;
   logic              w_wr_hit;
   logic [IDX_W-1:0]  w_wr_idx;
   logic              w_commit;

   assign w_wr_ofs = {1'b0, aw_addr_q} - {1'b0, BASE_ADDR};
   assign w_wr_hit = (aw_addr_q >= BASE_ADDR) && (w_wr_ofs < SPAN);
   assign w_wr_idx = w_wr_ofs[IDX_W+OFS_W-1 -: IDX_W];
   // Derived purely from registered state, so an async reset kills it at once.
   assign w_commit = (w_state_q == W_DLY) && (w_cnt_q == WR_CNT) && w_wr_hit;

   always_comb begin
      w_state_d = w_state_q;
      w_cnt_d   = w_cnt_q;
      aw_addr_d = aw_addr_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      aw_got_d  = aw_got_q;
      w_got_d   = w_got_q;
      b_resp_d  = b_resp_q;
      b_valid_d = b_valid_q;
      case (w_state_q)
         W_IDLE: begin
            if (slv_aw_valid_i && aw_ready_q) begin
               aw_addr_d = slv_aw_addr_i;
               aw_got_d  = 1'b1;
            end
            if (slv_w_valid_i && w_ready_q) begin
               w_data_d = slv_w_data_i;
               w_strb_d = slv_w_strb_i;
               w_got_d  = 1'b1;
            end
            if (aw_got_d && w_got_d) begin
               w_cnt_d   = '0;
               w_state_d = W_DLY;
            end
         end
         W_DLY: begin
            if (w_cnt_q == WR_CNT) begin
               w_state_d = W_RSP;
               b_valid_d = 1'b1;
               b_resp_d  = w_wr_hit ? OKAY : DECERR;
            end else begin
               w_cnt_d = w_cnt_q + 4'd1;
            end
         end
         W_RSP: begin
            if (slv_b_ready_i) begin
               b_valid_d = 1'b0;
               aw_got_d  = 1'b0;
               w_got_d   = 1'b0;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
      aw_ready_d = (w_state_d == W_IDLE) && !aw_got_d;
      w_ready_d  = (w_state_d == W_IDLE) && !w_got_d;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         w_state_q  <= W_IDLE;
         w_cnt_q    <= '0;
         aw_addr_q  <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         aw_got_q   <= 1'b0;
         w_got_q    <= 1'b0;
         b_resp_q   <= OKAY;
         b_valid_q  <= 1'b0;
         aw_ready_q <= 1'b0;
         w_ready_q  <= 1'b0;
      end else begin
         w_state_q  <= w_state_d;
         w_cnt_q    <= w_cnt_d;
         aw_addr_q  <= aw_addr_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         aw_got_q   <= aw_got_d;
         w_got_q    <= w_got_d;
         b_resp_q   <= b_resp_d;
         b_valid_q  <= b_valid_d;
         aw_ready_q <= aw_ready_d;
         w_ready_q  <= w_ready_d;
      end
   end

   // Storage is deliberately outside the reset domain so contents survive reset.
   always_ff @(posedge clk_i) begin
      if (w_commit) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (w_strb_q[b]) begin
               mem_q[w_wr_idx][8*b +: 8] <= w_data_q[8*b +: 8];
            end
         end
      end
   end

   assign slv_ar_ready_o = ar_ready_q;
   assign slv_r_valid_o  = r_valid_q;
   assign slv_r_data_o   = r_data_q;
   assign slv_r_resp_o   = r_resp_q;
   assign slv_aw_ready_o = aw_ready_q;
   assign slv_w_ready_o  = w_ready_q;
   assign slv_b_valid_o  = b_valid_q;
   assign slv_b_resp_o   = b_resp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_sram_slv.sv
`default_nettype none
// ============================================================================
// tb_axi_lite_sram_slv : vector table, corner sequences and random traffic
//                        against a word-array model of the SRAM responder.
// Revision 1.0
// ============================================================================
module tb_axi_lite_sram_slv;

   localparam int          RD_LAT = 2;
   localparam int          WR_LAT = 2;
   localparam int          DEPTH  = 1024;
   localparam logic [31:0] BASE   = 32'h8000_0000;
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  DECERR = 2'b11;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        slv_ar_valid_i = 1'b0;
   logic [31:0] slv_ar_addr_i = '0;
   logic        slv_ar_ready_o;
   logic        slv_r_valid_o;
   logic [31:0] slv_r_data_o;
   logic [1:0]  slv_r_resp_o;
   logic        slv_r_ready_i = 1'b0;
   logic        slv_aw_valid_i = 1'b0;
   logic [31:0] slv_aw_addr_i = '0;
   logic        slv_aw_ready_o;
   logic        slv_w_valid_i = 1'b0;
   logic [31:0] slv_w_data_i = '0;
   logic [3:0]  slv_w_strb_i = '0;
   logic        slv_w_ready_o;
   logic        slv_b_valid_o;
   logic [1:0]  slv_b_resp_o;
   logic        slv_b_ready_i = 1'b0;

   always #5 clk_i = ~clk_i;

   axi_lite_sram_slv #(
      .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE),
      .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_addr_i(slv_ar_addr_i), .slv_ar_ready_o(slv_ar_ready_o),
      .slv_r_valid_o(slv_r_valid_o), .slv_r_data_o(slv_r_data_o), .slv_r_resp_o(slv_r_resp_o),
      .slv_r_ready_i(slv_r_ready_i),
      .slv_aw_valid_i(slv_aw_valid_i), .slv_aw_addr_i(slv_aw_addr_i), .slv_aw_ready_o(slv_aw_ready_o),
      .slv_w_valid_i(slv_w_valid_i), .slv_w_data_i(slv_w_data_i), .slv_w_strb_i(slv_w_strb_i),
      .slv_w_ready_o(slv_w_ready_o),
      .slv_b_valid_o(slv_b_valid_o), .slv_b_resp_o(slv_b_resp_o), .slv_b_ready_i(slv_b_ready_i)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] mdl [int];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout expected handshake", name);
   endtask

   // ---------------- reference model ----------------
   function automatic bit in_rng(input logic [31:0] a);
      return (a >= BASE) && ((a - BASE) < 32'(DEPTH * 4));
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      logic [31:0] w;
      resp = DECERR;
      if (in_rng(a)) begin
         resp = OKAY;
         w = mdl.exists(widx(a)) ? mdl[widx(a)] : 32'h0;
         for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
         mdl[widx(a)] = w;
      end
   endtask

   task automatic mdl_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      d = 32'h0;
      resp = DECERR;
      if (in_rng(a)) begin
         resp = OKAY;
         d = mdl.exists(widx(a)) ? mdl[widx(a)] : 32'h0;
      end
   endtask

   // ---------------- bus tasks (called at a negedge, return at a negedge) ----------------
   // w_lead > 0: W shown that many cycles before AW; < 0: AW leads.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead, input int b_hold, output logic [1:0] resp);
      int aw_at, w_at, k, n;
      bit aw_done, w_done, hs_aw, hs_w, rdy_bad, hold_bad;
      logic [1:0] resp0;
      aw_at = (w_lead > 0) ? w_lead : 0;
      w_at  = (w_lead < 0) ? -w_lead : 0;
      aw_done = 0; w_done = 0; k = 0; rdy_bad = 0; hold_bad = 0; resp = '0;
      while (!(aw_done && w_done) && k < 64) begin
         slv_aw_valid_i = !aw_done && (k >= aw_at);
         slv_aw_addr_i  = addr;
         slv_w_valid_i  = !w_done && (k >= w_at);
         slv_w_data_i   = data;
         slv_w_strb_i   = strb;
         if ((aw_done && slv_aw_ready_o) || (w_done && slv_w_ready_o)) rdy_bad = 1;
         hs_aw = slv_aw_valid_i && slv_aw_ready_o;
         hs_w  = slv_w_valid_i && slv_w_ready_o;
         @(posedge clk_i);
         aw_done = aw_done || hs_aw;
         w_done  = w_done || hs_w;
         @(negedge clk_i);
         k++;
      end
      slv_aw_valid_i = 1'b0;
      slv_w_valid_i  = 1'b0;
      if (!(aw_done && w_done)) begin
         fail("wr_accept");
         return;
      end
      n = 0;
      while (!slv_b_valid_o && n < 64) begin
         if (slv_aw_ready_o || slv_w_ready_o) rdy_bad = 1;
         @(posedge clk_i);
         @(negedge clk_i);
         n++;
      end
      check("wr_ready_low", 32'(rdy_bad), 0);
      check("b_latency", n, WR_LAT + 1);
      resp0 = slv_b_resp_o;
      for (int i = 0; i < b_hold; i++) begin
         @(posedge clk_i);
         @(negedge clk_i);
         if (!slv_b_valid_o || slv_b_resp_o !== resp0 || slv_aw_ready_o || slv_w_ready_o) hold_bad = 1;
      end
      check("b_hold", 32'(hold_bad), 0);
      slv_b_ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      slv_b_ready_i = 1'b0;
      check("b_done", {slv_b_valid_o, slv_aw_ready_o, slv_w_ready_o}, 3'b011);
      resp = resp0;
   endtask

   task automatic do_read(input logic [31:0] addr, input int r_hold,
                          output logic [31:0] data, output logic [1:0] resp);
      int k, n;
      bit bad;
      data = '0; resp = '0; k = 0; bad = 0;
      slv_ar_valid_i = 1'b1;
      slv_ar_addr_i  = addr;
      while (!slv_ar_ready_o && k < 64) begin
         @(posedge clk_i);
         @(negedge clk_i);
         k++;
      end
      if (!slv_ar_ready_o) begin
         slv_ar_valid_i = 1'b0;
         fail("ar_accept");
         return;
      end
      @(posedge clk_i);
      @(negedge clk_i);
      slv_ar_valid_i = 1'b0;
      n = 0;
      while (!slv_r_valid_o && n < 64) begin
         if (slv_ar_ready_o) bad = 1;
         @(posedge clk_i);
         @(negedge clk_i);
         n++;
      end
      check("r_latency", n, RD_LAT + 1);
      data = slv_r_data_o;
      resp = slv_r_resp_o;
      for (int i = 0; i < r_hold; i++) begin
         @(posedge clk_i);
         @(negedge clk_i);
         if (!slv_r_valid_o || slv_r_data_o !== data || slv_r_resp_o !== resp || slv_ar_ready_o) bad = 1;
      end
      check("r_hold", 32'(bad), 0);
      slv_r_ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      slv_r_ready_i = 1'b0;
      check("r_done", {slv_r_valid_o, slv_ar_ready_o}, 2'b01);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          lead;
      int          hold;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t tbl [15];

   initial begin
      logic [1:0]  rsp, mrsp, rsp2;
      logic [31:0] rd, mrd;
      logic [31:0] a, d;
      logic [3:0]  s;

      tbl[0]  = '{1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF,  0, 5, OKAY,   32'h0};
      tbl[1]  = '{0, 32'h8000_0010, 32'h0,         4'h0,  0, 5, OKAY,   32'hDEAD_BEEF};
      tbl[2]  = '{1, 32'h8000_0010, 32'h1234_5678, 4'h3,  3, 0, OKAY,   32'h0};
      tbl[3]  = '{0, 32'h8000_0010, 32'h0,         4'h0,  0, 0, OKAY,   32'hDEAD_5678};
      tbl[4]  = '{1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, -2, 1, OKAY,   32'h0};
      tbl[5]  = '{0, 32'h7FFF_FFFC, 32'h0,         4'h0,  0, 1, DECERR, 32'h0};
      tbl[6]  = '{1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF,  0, 0, DECERR, 32'h0};
      tbl[7]  = '{0, 32'h8000_0000, 32'h0,         4'h0,  0, 0, OKAY,   32'h0BAD_F00D};
      tbl[8]  = '{1, 32'h8000_0000, 32'hAAAA_AAAA, 4'h0,  1, 0, OKAY,   32'h0};
      tbl[9]  = '{0, 32'h8000_0003, 32'h0,         4'h0,  0, 0, OKAY,   32'h0BAD_F00D};
      tbl[10] = '{1, 32'h8000_0FFC, 32'h1122_3344, 4'hF,  0, 0, OKAY,   32'h0};
      tbl[11] = '{0, 32'h8000_0FFC, 32'h0,         4'h0,  0, 0, OKAY,   32'h1122_3344};
      tbl[12] = '{0, 32'h8000_1000, 32'h0,         4'h0,  0, 0, DECERR, 32'h0};
      tbl[13] = '{1, 32'h8000_0FFE, 32'h5566_7788, 4'hC,  0, 2, OKAY,   32'h0};
      tbl[14] = '{0, 32'h8000_0FFC, 32'h0,         4'h0,  0, 0, OKAY,   32'h5566_3344};

      // reset state, then first edge after release raises the readies
      #1 rst_i = 1'b0;
      #2;
      check("rst_r_valid", 32'(slv_r_valid_o), 0);
      check("rst_b_valid", 32'(slv_b_valid_o), 0);
      check("rst_readies", {slv_ar_ready_o, slv_aw_ready_o, slv_w_ready_o}, 3'b000);
      check("rst_r_data", slv_r_data_o, 0);
      check("rst_resps", {slv_r_resp_o, slv_b_resp_o}, 4'b0000);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
      check("rel_readies_pre", {slv_ar_ready_o, slv_aw_ready_o, slv_w_ready_o}, 3'b000);
      @(posedge clk_i);
      @(negedge clk_i);
      check("rel_readies", {slv_ar_ready_o, slv_aw_ready_o, slv_w_ready_o}, 3'b111);

      // directed vector table
      for (int i = 0; i < 15; i++) begin
         if (tbl[i].wr) begin
            do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].lead, tbl[i].hold, rsp);
            mdl_write(tbl[i].addr, tbl[i].data, tbl[i].strb, mrsp);
            check($sformatf("tbl%0d_bresp", i), 32'(rsp), 32'(tbl[i].exp_resp));
         end else begin
            do_read(tbl[i].addr, tbl[i].hold, rd, rsp);
            check($sformatf("tbl%0d_rresp", i), 32'(rsp), 32'(tbl[i].exp_resp));
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
         end
      end

      // read capture and write commit on the same edge: old data, then new
      mdl_read(32'h8000_0010, mrd, mrsp);
      fork
         begin
            do_write(32'h8000_0010, 32'hCAFE_F00D, 4'hF, 0, 0, rsp2);
         end
         begin
            do_read(32'h8000_0010, 0, rd, rsp);
         end
      join
      mdl_write(32'h8000_0010, 32'hCAFE_F00D, 4'hF, mrsp);
      check("coll_old_data", rd, 32'hDEAD_5678);
      check("coll_bresp", 32'(rsp2), 32'(OKAY));
      do_read(32'h8000_0010, 0, rd, rsp);
      check("coll_new_data", rd, 32'hCAFE_F00D);

      // reset pulsed while a write sits in its delay stage
      do_write(32'h8000_0020, 32'h0102_0304, 4'hF, 0, 0, rsp);
      mdl_write(32'h8000_0020, 32'h0102_0304, 4'hF, mrsp);
      slv_aw_valid_i = 1'b1; slv_aw_addr_i = 32'h8000_0020;
      slv_w_valid_i  = 1'b1; slv_w_data_i  = 32'h9999_9999; slv_w_strb_i = 4'hF;
      slv_ar_valid_i = 1'b1; slv_ar_addr_i = 32'h8000_0020;
      @(posedge clk_i);
      @(negedge clk_i);
      slv_aw_valid_i = 1'b0; slv_w_valid_i = 1'b0; slv_ar_valid_i = 1'b0;
      check("rstw_accepted", {slv_ar_ready_o, slv_aw_ready_o, slv_w_ready_o}, 3'b000);
      @(posedge clk_i);
      #2 rst_i = 1'b0;
      #1;
      check("rstw_valids", {slv_r_valid_o, slv_b_valid_o}, 2'b00);
      check("rstw_readies", {slv_ar_ready_o, slv_aw_ready_o, slv_w_ready_o}, 3'b000);
      @(negedge clk_i);
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      check("rstw_readies_up", {slv_ar_ready_o, slv_aw_ready_o, slv_w_ready_o}, 3'b111);
      do_read(32'h8000_0020, 0, rd, rsp);
      check("rstw_unchanged", rd, 32'h0102_0304);

      // random traffic: seed a window of words, then mix reads/writes
      for (int i = 0; i < 16; i++) begin
         d = $urandom;
         do_write(BASE + 32'(4 * i), d, 4'hF, 0, 0, rsp);
         mdl_write(BASE + 32'(4 * i), d, 4'hF, mrsp);
      end
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            if ($urandom_range(0, 1) == 1) a = BASE - 32'(4 * (1 + $urandom_range(0, 15)));
            else                           a = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 15));
         end else begin
            a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            do_write(a, d, s, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)), rsp);
            mdl_write(a, d, s, mrsp);
            check($sformatf("rnd%0d_bresp", i), 32'(rsp), 32'(mrsp));
         end else begin
            do_read(a, int'($urandom_range(0, 2)), rd, rsp);
            mdl_read(a, mrd, mrsp);
            check($sformatf("rnd%0d_rresp", i), 32'(rsp), 32'(mrsp));
            check($sformatf("rnd%0d_rdata", i), rd, mrd);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/axi_lite_sram_slv.md
AXI_LITE_SRAM_SLV -- requirements
Module: axi_lite_sram_slv

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width; strobe width is DATA_W/8.
- DEPTH, 1024, number of DATA_W words in memory.
- BASE_ADDR, 32'h8000_0000, first byte address decoded.
- RD_LAT, 2, added read delay in cycles (0..15).
- WR_LAT, 2, added write delay in cycles (0..15).

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk_i, in, 1, single clock; all logic on the rising edge.
- rst_i, in, 1, reset; asynchronous, active-low.
- slv_ar_valid_i / slv_ar_addr_i / slv_ar_ready_o, in/in/out, 1/ADDR_W/1, read address channel.
- slv_r_valid_o / slv_r_data_o / slv_r_resp_o / slv_r_ready_i, out/out/out/in, 1/DATA_W/2/1, read data channel.
- slv_aw_valid_i / slv_aw_addr_i / slv_aw_ready_o, in/in/out, 1/ADDR_W/1, write address channel.
- slv_w_valid_i / slv_w_data_i / slv_w_strb_i / slv_w_ready_o, in/in/in/out, 1/DATA_W/DATA_W/8/1, write data channel.
- slv_b_valid_o / slv_b_resp_o / slv_b_ready_i, out/out/in, 1/2/1, write response channel.

Function
REQ-003 The block SHALL be an AXI4-Lite responder; a handshake occurs when valid and ready are both high on a rising edge.
REQ-004 Response codes SHALL be: OKAY = 2'b00, DECERR = 2'b11.
REQ-005 An address is in range when BASE_ADDR <= addr < BASE_ADDR + DEPTH*DATA_W/8; the word index is (addr - BASE_ADDR) >> log2(DATA_W/8), and the low address bits are ignored.
REQ-006 The read FSM SHALL have the states R_IDLE -> R_DLY -> R_RSP -> R_IDLE. slv_ar_ready_o SHALL be high only in R_IDLE.
REQ-007 On an AR handshake the read FSM SHALL latch the address and enter R_DLY. It SHALL count RD_LAT cycles, then enter R_RSP and capture data and response in the same edge. With RD_LAT=0 it SHALL pass through R_DLY in 1 cycle.
REQ-008 AR handshake at cycle T SHALL give slv_r_valid_o high at T+2+RD_LAT. In R_RSP, rvalid, rdata and rresp SHALL stay stable until the R handshake, and the FSM SHALL then return to R_IDLE.
REQ-009 An out-of-range read SHALL return DECERR with rdata = 0. An in-range read SHALL return OKAY with the memory word.
REQ-010 The write FSM SHALL have the states W_IDLE -> W_DLY -> W_RSP -> W_IDLE.
REQ-011 In W_IDLE, AW and W SHALL be accepted independently and in either order, or in the same cycle. Each ready SHALL drop on the cycle after its own handshake and stay low until W_RSP completes.
REQ-012 When both AW and W have been latched, the write FSM SHALL enter W_DLY and count WR_LAT cycles. On the edge into W_RSP it SHALL commit the write and set bvalid.
REQ-013 A commit SHALL write only the byte lanes whose strobe bit is 1. wstrb = 0 SHALL leave memory unchanged and return OKAY.
REQ-014 An out-of-range write SHALL leave memory unchanged and return DECERR.
REQ-015 bvalid and bresp SHALL stay stable until the B handshake. The write FSM SHALL then return to W_IDLE with awready and wready high on the next cycle.
REQ-016 The read and write FSMs SHALL run concurrently. If a read capture and a write commit to the same word fall on the same edge, the read SHALL return the pre-write data.
REQ-017 At most one read and one write SHALL be outstanding; there is no ID or burst support.
REQ-018 All outputs SHALL be registered.

Reset
REQ-019 While rst_i is low: both FSMs SHALL be in IDLE; rvalid, bvalid, arready, awready and wready SHALL be 0; rdata = 0 and rresp = bresp = 2'b00.
REQ-020 On the first rising edge after rst_i deasserts, arready, awready and wready SHALL go to 1.
REQ-021 A reset asserted mid-transaction SHALL abandon it immediately. An uncommitted write SHALL never reach memory.
REQ-022 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-023 With RD_LAT=2, WR_LAT=2, the bench SHALL cover:
- Write 0x8000_0010 data 0xDEADBEEF strb 0xF, then read the same address -> bvalid 4 cycles after the second of AW/W accepted with OKAY; rvalid at T+4 with 0xDEADBEEF, OKAY.
- W presented 3 cycles before AW, then strb 0x3 data 0x1234_5678 over 0xDEADBEEF -> readback 0xDEAD5678.
- Read 0x7FFF_FFFC and write 0x8000_1000 (DEPTH=1024) -> DECERR on both, rdata 0, memory unchanged.
- rready held low 5 cycles -> rvalid and rdata stable, arready stays 0 throughout; bready low likewise holds bvalid and bresp.
- Read and write to the same word with read capture on the commit edge -> old data returned; a later read returns new data.
- rst_i pulsed low during W_DLY -> all valids 0 asynchronously, readies 1 one edge after release, target word unchanged.
